// File: rtl/oc_dispatch_xbar.sv
`default_nettype none
// ============================================================================
// Module   : oc_dispatch_xbar
// Purpose  : Operand-collector to execution-unit dispatch crossbar with
//            per-EU round-robin arbitration and valid/ready output registers.
// Revision : 1.0
// ============================================================================
module oc_dispatch_xbar #(
    parameter int NUM_OC = 4,
    parameter int NUM_EU = 2,
    parameter int DATA_W = 256,
    parameter int CTRL_W = 74,
    parameter int EU_W   = (NUM_EU > 1) ? $clog2(NUM_EU) : 1,
    parameter int SRC_W  = (NUM_OC > 1) ? $clog2(NUM_OC) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_OC-1:0]          oc_req,
    input  logic [NUM_OC*EU_W-1:0]     oc_eu_sel,
    input  logic [NUM_OC*DATA_W-1:0]   oc_data0,
    input  logic [NUM_OC*DATA_W-1:0]   oc_data1,
    input  logic [NUM_OC*CTRL_W-1:0]   oc_ctrl,
    output logic [NUM_OC-1:0]          oc_grant,
    output logic [NUM_EU-1:0]          eu_valid,
    input  logic [NUM_EU-1:0]          eu_ready,
    output logic [NUM_EU*DATA_W-1:0]   eu_data0,
    output logic [NUM_EU*DATA_W-1:0]   eu_data1,
    output logic [NUM_EU*CTRL_W-1:0]   eu_ctrl,
    output logic [NUM_EU*SRC_W-1:0]    eu_src,
    output logic [NUM_EU*16-1:0]       eu_busy_cnt
);

    logic [NUM_EU-1:0][NUM_OC-1:0] w_gnt;

    for (genvar j = 0; j < NUM_EU; j++) begin : g_eu
        logic [NUM_OC-1:0] w_req;
        logic [NUM_OC-1:0] w_gnt_row;
        logic              w_free;
        logic              w_found;
        logic              w_hi_found;
        logic              w_lo_found;
        logic [SRC_W-1:0]  w_hi_idx;
        logic [SRC_W-1:0]  w_lo_idx;
        logic [SRC_W-1:0]  w_win;
        logic              valid_q, valid_d;
        logic [DATA_W-1:0] data0_q, data0_d;
        logic [DATA_W-1:0] data1_q, data1_d;
        logic [CTRL_W-1:0] ctrl_q, ctrl_d;
        logic [SRC_W-1:0]  src_q, src_d;
        logic [SRC_W-1:0]  ptr_q, ptr_d;
        logic [15:0]       busy_q, busy_d;

        // Out-of-range selects never match any EU index, so they are ignored.
        for (genvar i = 0; i < NUM_OC; i++) begin : g_req
            assign w_req[i] = oc_req[i] && (oc_eu_sel[i*EU_W +: EU_W] == EU_W'(j));
        end

        assign w_free = !valid_q || eu_ready[j];

        // Round robin: the first requester at or above ptr wins, else the lowest.
        always_comb begin
            w_hi_found = 1'b0;
            w_lo_found = 1'b0;
            w_hi_idx   = '0;
            w_lo_idx   = '0;
            for (int i = 0; i < NUM_OC; i++) begin
                if (w_req[i] && !w_lo_found) begin
                    w_lo_found = 1'b1;
                    w_lo_idx   = SRC_W'(i);
                end
                if (w_req[i] && !w_hi_found && (SRC_W'(i) >= ptr_q)) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = SRC_W'(i);
                end
            end
            w_win     = w_hi_found ? w_hi_idx : w_lo_idx;
            w_found   = rst && w_free && w_lo_found;
            w_gnt_row = w_found ? (NUM_OC'(1) << w_win) : '0;
        end

        assign w_gnt[j] = w_gnt_row;

        always_comb begin
            valid_d = valid_q;
            data0_d = data0_q;
            data1_d = data1_q;
            ctrl_d  = ctrl_q;
            src_d   = src_q;
            ptr_d   = ptr_q;
            if (w_found) begin
                valid_d = 1'b1;
                src_d   = w_win;
                ptr_d   = (w_win == SRC_W'(NUM_OC - 1)) ? '0 : w_win + SRC_W'(1);
                for (int i = 0; i < NUM_OC; i++) begin
                    if (w_gnt_row[i]) begin
                        data0_d = oc_data0[i*DATA_W +: DATA_W];
                        data1_d = oc_data1[i*DATA_W +: DATA_W];
                        ctrl_d  = oc_ctrl[i*CTRL_W +: CTRL_W];
                    end
                end
            end else if (eu_ready[j]) begin
                valid_d = 1'b0;
            end
            busy_d = busy_q;
            if (valid_q && !eu_ready[j] && (busy_q != 16'hFFFF)) begin
                busy_d = busy_q + 16'd1;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                valid_q <= 1'b0;
                data0_q <= '0;
                data1_q <= '0;
                ctrl_q  <= '0;
                src_q   <= '0;
                ptr_q   <= '0;
                busy_q  <= '0;
            end else begin
                valid_q <= valid_d;
                data0_q <= data0_d;
                data1_q <= data1_d;
                ctrl_q  <= ctrl_d;
                src_q   <= src_d;
                ptr_q   <= ptr_d;
                busy_q  <= busy_d;
            end
        end

        assign eu_valid[j]                  = valid_q;
        assign eu_data0[j*DATA_W +: DATA_W] = data0_q;
        assign eu_data1[j*DATA_W +: DATA_W] = data1_q;
        assign eu_ctrl[j*CTRL_W +: CTRL_W]  = ctrl_q;
        assign eu_src[j*SRC_W +: SRC_W]     = src_q;
        assign eu_busy_cnt[j*16 +: 16]      = busy_q;
    end

    always_comb begin
        oc_grant = '0;
        for (int j = 0; j < NUM_EU; j++) begin
            oc_grant = oc_grant | w_gnt[j];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_oc_dispatch_xbar.sv
`default_nettype none
// ============================================================================
// Module   : tb_oc_dispatch_xbar
// Purpose  : Directed self-checking bench for oc_dispatch_xbar.
// Revision : 1.0
// ============================================================================
module tb_oc_dispatch_xbar;

    localparam int NUM_OC = 4;
    localparam int NUM_EU = 2;
    localparam int DATA_W = 256;
    localparam int CTRL_W = 74;
    localparam int EU_W   = 2;
    localparam int SRC_W  = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_OC-1:0]        oc_req;
    logic [NUM_OC*EU_W-1:0]   oc_eu_sel;
    logic [NUM_OC*DATA_W-1:0] oc_data0;
    logic [NUM_OC*DATA_W-1:0] oc_data1;
    logic [NUM_OC*CTRL_W-1:0] oc_ctrl;
    logic [NUM_OC-1:0]        oc_grant;
    logic [NUM_EU-1:0]        eu_valid;
    logic [NUM_EU-1:0]        eu_ready;
    logic [NUM_EU*DATA_W-1:0] eu_data0;
    logic [NUM_EU*DATA_W-1:0] eu_data1;
    logic [NUM_EU*CTRL_W-1:0] eu_ctrl;
    logic [NUM_EU*SRC_W-1:0]  eu_src;
    logic [NUM_EU*16-1:0]     eu_busy_cnt;

    int checks   = 0;
    int failures = 0;

    oc_dispatch_xbar #(
        .NUM_OC(NUM_OC), .NUM_EU(NUM_EU), .DATA_W(DATA_W),
        .CTRL_W(CTRL_W), .EU_W(EU_W)
    ) dut (
        .clk(clk), .rst(rst),
        .oc_req(oc_req), .oc_eu_sel(oc_eu_sel),
        .oc_data0(oc_data0), .oc_data1(oc_data1), .oc_ctrl(oc_ctrl),
        .oc_grant(oc_grant),
        .eu_valid(eu_valid), .eu_ready(eu_ready),
        .eu_data0(eu_data0), .eu_data1(eu_data1), .eu_ctrl(eu_ctrl),
        .eu_src(eu_src), .eu_busy_cnt(eu_busy_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; oc_req = '0; oc_eu_sel = '0; eu_ready = '0;
        oc_data0 = '0; oc_data1 = '0; oc_ctrl = '0;
        #1;
        checks++; if (eu_valid !== 2'b00) begin failures++; $display("FAIL reset_valid: got %b exp 00", eu_valid); end
        checks++; if (oc_grant !== 4'b0000) begin failures++; $display("FAIL reset_grant: got %b exp 0000", oc_grant); end
        checks++; if (eu_busy_cnt !== 32'd0) begin failures++; $display("FAIL reset_busy: got %h exp 0", eu_busy_cnt); end
        tick();
        rst = 1'b1;
        tick();
        checks++; if (eu_valid !== 2'b00 || eu_src !== 4'h0 || eu_ctrl !== '0 || eu_data0 !== '0)
            begin failures++; $display("FAIL idle_outputs: got valid=%b src=%h exp valid=00 src=0", eu_valid, eu_src); end
    endtask

    task automatic test_single();
        logic [CTRL_W-1:0] c;
        c = {32'h1234_5678, 1'b1, 16'hABCD, 1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 8'hF0, 5'h1F};
        oc_data0[2*DATA_W +: DATA_W] = {8{32'hA5A5_0001}};
        oc_data1[2*DATA_W +: DATA_W] = {8{32'h5A5A_0002}};
        oc_ctrl[2*CTRL_W +: CTRL_W]  = c;
        oc_eu_sel[2*EU_W +: EU_W]    = 2'd1;
        oc_req   = 4'b0100;
        eu_ready = 2'b11;
        #1;
        checks++; if (oc_grant !== 4'b0100) begin failures++; $display("FAIL single_grant: got %b exp 0100", oc_grant); end
        tick();
        oc_req = 4'b0000;
        #1;
        checks++; if (eu_valid !== 2'b10) begin failures++; $display("FAIL single_valid: got %b exp 10", eu_valid); end
        checks++; if (eu_src[SRC_W +: SRC_W] !== 2'd2) begin failures++; $display("FAIL single_src: got %0d exp 2", eu_src[SRC_W +: SRC_W]); end
        checks++; if (eu_data0[DATA_W +: DATA_W] !== {8{32'hA5A5_0001}}) begin failures++; $display("FAIL single_data0: got %h", eu_data0[DATA_W +: 32]); end
        checks++; if (eu_data1[DATA_W +: DATA_W] !== {8{32'h5A5A_0002}}) begin failures++; $display("FAIL single_data1: got %h", eu_data1[DATA_W +: 32]); end
        checks++; if (eu_ctrl[CTRL_W +: CTRL_W] !== c) begin failures++; $display("FAIL single_ctrl: got %h exp %h", eu_ctrl[CTRL_W +: CTRL_W], c); end
        checks++; if (oc_grant !== 4'b0000) begin failures++; $display("FAIL single_grant_pulse: got %b exp 0000", oc_grant); end
        tick();
        checks++; if (eu_valid !== 2'b00) begin failures++; $display("FAIL single_drain: got %b exp 00", eu_valid); end
        checks++; if (eu_data0[DATA_W +: DATA_W] !== {8{32'hA5A5_0001}}) begin failures++; $display("FAIL single_hold_data: got %h", eu_data0[DATA_W +: 32]); end
    endtask

    task automatic test_round_robin();
        int exp_oc;
        for (int i = 0; i < NUM_OC; i++) begin
            oc_data0[i*DATA_W +: DATA_W] = {8{32'h1000_0000 + 32'(i)}};
            oc_eu_sel[i*EU_W +: EU_W]    = 2'd0;
        end
        oc_req   = 4'b1111;
        eu_ready = 2'b11;
        #1;
        for (int k = 0; k < 5; k++) begin
            exp_oc = k % NUM_OC;
            checks++; if (oc_grant !== (4'b0001 << exp_oc)) begin failures++; $display("FAIL rr_grant%0d: got %b exp oc%0d", k, oc_grant, exp_oc); end
            tick();
            checks++; if (eu_valid[0] !== 1'b1 || eu_src[1:0] !== 2'(exp_oc))
                begin failures++; $display("FAIL rr_capture%0d: got valid=%b src=%0d exp valid=1 src=%0d", k, eu_valid[0], eu_src[1:0], exp_oc); end
            checks++; if (eu_data0[31:0] !== 32'h1000_0000 + 32'(exp_oc)) begin failures++; $display("FAIL rr_data%0d: got %h", k, eu_data0[31:0]); end
        end
        oc_req = 4'b0000;
        tick();
        checks++; if (eu_valid !== 2'b00) begin failures++; $display("FAIL rr_drain: got %b exp 00", eu_valid); end
    endtask

    task automatic test_back_pressure();
        oc_eu_sel = '0;
        oc_data0[1*DATA_W +: DATA_W] = {8{32'hB00B_0001}};
        oc_data0[2*DATA_W +: DATA_W] = {8{32'hB00B_0002}};
        oc_req   = 4'b0010;
        eu_ready = 2'b10;
        #1;
        checks++; if (oc_grant !== 4'b0010) begin failures++; $display("FAIL bp_grant: got %b exp 0010", oc_grant); end
        tick();
        oc_req = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (oc_grant !== 4'b0000) begin failures++; $display("FAIL bp_no_grant%0d: got %b exp 0000", k, oc_grant); end
            checks++; if (eu_valid[0] !== 1'b1 || eu_src[1:0] !== 2'd1 || eu_data0[31:0] !== 32'hB00B_0001)
                begin failures++; $display("FAIL bp_hold%0d: got valid=%b src=%0d data=%h exp 1/1/b00b0001", k, eu_valid[0], eu_src[1:0], eu_data0[31:0]); end
            tick();
        end
        checks++; if (eu_busy_cnt[15:0] !== 16'd5) begin failures++; $display("FAIL bp_busy: got %0d exp 5", eu_busy_cnt[15:0]); end
        eu_ready = 2'b11;
        #1;
        checks++; if (oc_grant !== 4'b0100) begin failures++; $display("FAIL bp_refill_grant: got %b exp 0100", oc_grant); end
        tick();
        oc_req = 4'b0000;
        checks++; if (eu_valid[0] !== 1'b1 || eu_src[1:0] !== 2'd2 || eu_data0[31:0] !== 32'hB00B_0002)
            begin failures++; $display("FAIL bp_refill: got valid=%b src=%0d data=%h exp 1/2/b00b0002", eu_valid[0], eu_src[1:0], eu_data0[31:0]); end
        tick();
        checks++; if (eu_valid !== 2'b00 || eu_busy_cnt[15:0] !== 16'd5)
            begin failures++; $display("FAIL bp_drain: got valid=%b busy=%0d exp 00/5", eu_valid, eu_busy_cnt[15:0]); end
    endtask

    task automatic test_parallel();
        oc_data0[0*DATA_W +: DATA_W] = {8{32'hC0DE_0000}};
        oc_data0[3*DATA_W +: DATA_W] = {8{32'hC0DE_0003}};
        oc_eu_sel = 8'b01_00_00_00;
        oc_req    = 4'b1001;
        eu_ready  = 2'b11;
        #1;
        checks++; if (oc_grant !== 4'b1001) begin failures++; $display("FAIL par_grant: got %b exp 1001", oc_grant); end
        tick();
        oc_req = 4'b0000;
        checks++; if (eu_valid !== 2'b11 || eu_src !== 4'b11_00)
            begin failures++; $display("FAIL par_capture: got valid=%b src=%b exp 11/1100", eu_valid, eu_src); end
        checks++; if (eu_data0[31:0] !== 32'hC0DE_0000 || eu_data0[DATA_W +: 32] !== 32'hC0DE_0003)
            begin failures++; $display("FAIL par_data: got %h/%h exp c0de0000/c0de0003", eu_data0[31:0], eu_data0[DATA_W +: 32]); end
    endtask

    task automatic test_illegal();
        oc_eu_sel = 8'b00_00_11_00;
        oc_req    = 4'b0110;
        #1;
        checks++; if (oc_grant !== 4'b0100) begin failures++; $display("FAIL ill_grant: got %b exp 0100", oc_grant); end
        tick();
        oc_req = 4'b0010;
        checks++; if (eu_valid !== 2'b01 || eu_src[1:0] !== 2'd2)
            begin failures++; $display("FAIL ill_capture: got valid=%b src=%0d exp 01/2", eu_valid, eu_src[1:0]); end
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (oc_grant !== 4'b0000) begin failures++; $display("FAIL ill_never%0d: got %b exp 0000", k, oc_grant); end
            tick();
        end
        checks++; if (eu_valid !== 2'b00) begin failures++; $display("FAIL ill_idle: got %b exp 00", eu_valid); end
        oc_req = 4'b0000;
    endtask

    task automatic test_async_reset();
        oc_eu_sel = '0;
        oc_req    = 4'b0001;
        eu_ready  = 2'b10;
        #1;
        checks++; if (oc_grant !== 4'b0001) begin failures++; $display("FAIL ar_grant: got %b exp 0001", oc_grant); end
        tick();
        checks++; if (eu_valid[0] !== 1'b1) begin failures++; $display("FAIL ar_hold: got %b exp 1", eu_valid[0]); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (eu_valid !== 2'b00 || eu_src !== 4'h0 || eu_data0 !== '0 || eu_busy_cnt !== 32'd0)
            begin failures++; $display("FAIL ar_clear: got valid=%b src=%h busy=%h exp 0", eu_valid, eu_src, eu_busy_cnt); end
        checks++; if (oc_grant !== 4'b0000) begin failures++; $display("FAIL ar_grant_in_reset: got %b exp 0000", oc_grant); end
        tick();
        rst    = 1'b1;
        oc_req = 4'b0000;
        #1;
        checks++; if (oc_grant !== 4'b0000) begin failures++; $display("FAIL ar_no_reissue: got %b exp 0000", oc_grant); end
        tick();
        checks++; if (eu_valid !== 2'b00) begin failures++; $display("FAIL ar_idle: got %b exp 00", eu_valid); end
        // ptr0 was 1 before reset; after reset OC0 must win over OC2.
        oc_req   = 4'b0101;
        eu_ready = 2'b11;
        #1;
        checks++; if (oc_grant !== 4'b0001) begin failures++; $display("FAIL ar_ptr_reset: got %b exp 0001", oc_grant); end
        tick();
        oc_req = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_back_pressure();
        test_parallel();
        test_illegal();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/oc_dispatch_xbar.md
Name: oc_dispatch_xbar

Overview:
- Parametrised dispatch crossbar between NUM_OC operand collectors and NUM_EU execution units (EU0 = ALU, EU1 = MEM by default).
- Each collector raises a request for one target EU; a per-EU round-robin arbiter selects one collector, returns a one-cycle dequeue grant, and captures the collector's operands and control bundle into a per-EU output register.
- The output register uses a valid/ready handshake.
- Replaces the externally-granted combinational 4:1 muxing. It adds internal fair arbitration, registered outputs and execution-unit back-pressure.

Parameters:
- NUM_OC, 4, number of operand collectors (>=2).
- NUM_EU, 2, number of execution units (>=1); EU index 0 = ALU, 1 = MEM.
- DATA_W, 256, width of each of the two operand vectors (8 lanes x 32 b).
- CTRL_W, 74, packed control bundle width: {Instr[31:0], RegWrite, Imme[15:0], Imme_Valid, ALUop[3:0], MemWrite, MemRead, Shared_Globalbar, BEQ, BLT, ScbID[1:0], ActiveMask[7:0], Dst[4:0]}, MSB first.
- EU_W, $clog2(NUM_EU) (min 1), width of the per-collector target select.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- oc_req  in  NUM_OC  collector i holds a ready-to-dispatch instruction.
- oc_eu_sel  in  NUM_OC*EU_W  target EU of collector i (slice i).
- oc_data0  in  NUM_OC*DATA_W  operand 0 of collector i.
- oc_data1  in  NUM_OC*DATA_W  operand 1 of collector i.
- oc_ctrl  in  NUM_OC*CTRL_W  control bundle of collector i.
- oc_grant  out  NUM_OC  one-cycle pulse: collector i dispatched, free its entry.
- eu_valid  out  NUM_EU  output register of EU j holds an instruction.
- eu_ready  in  NUM_EU  EU j accepts this cycle.
- eu_data0  out  NUM_EU*DATA_W  registered operand 0 for EU j.
- eu_data1  out  NUM_EU*DATA_W  registered operand 1 for EU j.
- eu_ctrl  out  NUM_EU*CTRL_W  registered control bundle for EU j.
- eu_src  out  NUM_EU*$clog2(NUM_OC)  collector index that sourced EU j's entry.
- eu_busy_cnt  out  NUM_EU*16  saturating count of cycles EU j was valid && !ready (stall statistics).

Behaviour:
- Reset (rst low, asynchronous):
  - eu_valid = 0; eu_data0/1, eu_ctrl, eu_src and eu_busy_cnt = 0.
  - oc_grant = 0.
  - All round-robin pointers = 0.
  - Reset asserted mid-transfer discards any held entry; no grant is reissued.
- Request decode: req_ij = oc_req[i] && (oc_eu_sel_i == j). If oc_eu_sel_i >= NUM_EU, the collector is ignored (never granted).
- Slot free: free_j = !eu_valid[j] || eu_ready[j]. This is a combinational pass-through of eu_ready, so a full register that is drained in the same cycle can be refilled; sustained throughput is 1 instruction/cycle/EU.
- Arbitration, per EU and combinational:
  - If free_j, grant goes to the first requester at or after ptr_j, searching upward with wrap (ptr_j, ptr_j+1, ..., NUM_OC-1, 0, ...).
  - If !free_j, EU j issues no grant.
- Grant output: oc_grant[i] = OR over j of gnt_ij. It is combinational in the cycle of selection (cycle T). At most one bit per EU; each collector targets exactly one EU, so it can never be double-granted.
- Capture: at the clk edge ending cycle T, a grant loads eu_data0/1, eu_ctrl and eu_src from the winner and sets eu_valid[j] = 1. Latency request->eu_valid is 1 cycle.
- Drain without refill: eu_valid && eu_ready with no grant -> eu_valid clears next edge. Data registers hold their last value.
- Hold: eu_valid && !eu_ready -> all EU j outputs stable. eu_busy_cnt_j increments, saturating at 16'hFFFF.
- Pointer update: on a grant to collector k, ptr_j <= (k+1) mod NUM_OC. With no grant, ptr_j holds. Pointers of different EUs are independent.
- Collector contract: oc_data/oc_ctrl stay stable while oc_req is high and until the grant cycle. A collector whose req drops before a grant is simply not selected.
- No bits of the payload are interpreted; ctrl fields are passed through intact.

Test Plan:
- Reset, then idle: all outputs 0, eu_busy_cnt = 0. Assert rst low mid-hold with eu_valid[0] = 1 -> eu_valid clears immediately, asynchronously.
- Single dispatch: OC2 req, sel = 1 (MEM), ctrl Dst = 5'h1F, data0 = {8{32'hA5A5_0001}}, eu_ready = 1 -> oc_grant = 4'b0100 in cycle T; next cycle eu_valid[1] = 1, eu_src = 2, payload matches.
- Round robin: OC0..OC3 all req sel = 0, eu_ready held 1 -> grants in order 0, 1, 2, 3, 0 on consecutive cycles; eu_valid[0] stays 1 throughout.
- Back-pressure: eu_ready[0] = 0 for 5 cycles with OC1 requesting ALU -> exactly one grant, outputs stable, no further grants, eu_busy_cnt_0 = 5. Raise ready -> next grant in the same cycle as the drain.
- Parallel EUs: OC0 sel = 0 and OC3 sel = 1 in the same cycle -> oc_grant = 4'b1001; both EUs valid next cycle with their correct sources.
- Illegal select: NUM_EU = 2, EU_W = 2 build, OC1 sel = 3 -> never granted; other collectors unaffected.
